decode_pipe_stage: RTL and testbench

DECODE_PIPE_STAGE -- requirements
Module: decode_pipe_stage

---
 rtl/decode_pipe_stage_if.sv | 46 ++++
 rtl/decode_pipe_stage.sv | 128 ++++++++++++
 tb/tb_decode_pipe_stage.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/decode_pipe_stage_if.sv
// Decode-stage bus: Decode-side operands, writeback port and the registered ID/EX outputs.
// master drives Decode/writeback inputs; slave is the decode stage itself.
interface decode_pipe_stage_if #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int CTRL_W = 10
);
   logic [31:0]       InstrD;
   logic [XLEN-1:0]   PCD;
   logic [XLEN-1:0]   PCPlus4D;
   logic [XLEN-1:0]   ImmExtD;
   logic [CTRL_W-1:0] CtrlD;
   logic              ValidD;
   logic              StallE;
   logic              FlushE;
   logic              RegWriteW;
   logic [REG_AW-1:0] RdW;
   logic [XLEN-1:0]   ResultW;

   logic [REG_AW-1:0] Rs1D;
   logic [REG_AW-1:0] Rs2D;
   logic [XLEN-1:0]   RD1E;
   logic [XLEN-1:0]   RD2E;
   logic [XLEN-1:0]   PCE;
   logic [XLEN-1:0]   ImmExtE;
   logic [XLEN-1:0]   PCPlus4E;
   logic [REG_AW-1:0] Rs1E;
   logic [REG_AW-1:0] Rs2E;
   logic [REG_AW-1:0] RdE;
   logic [CTRL_W-1:0] ControlE;
   logic              ValidE;

   modport master (
      output InstrD, PCD, PCPlus4D, ImmExtD, CtrlD, ValidD,
      output StallE, FlushE, RegWriteW, RdW, ResultW,
      input  Rs1D, Rs2D, RD1E, RD2E, PCE, ImmExtE, PCPlus4E,
      input  Rs1E, Rs2E, RdE, ControlE, ValidE
   );

   modport slave (
      input  InstrD, PCD, PCPlus4D, ImmExtD, CtrlD, ValidD,
      input  StallE, FlushE, RegWriteW, RdW, ResultW,
      output Rs1D, Rs2D, RD1E, RD2E, PCE, ImmExtE, PCPlus4E,
      output Rs1E, Rs2E, RdE, ControlE, ValidE
   );
endinterface

// File: rtl/decode_pipe_stage.sv
// Decode stage: register file with x0 hardwired to zero plus the ID/EX pipeline register.
// Define DECODE_PIPE_STAGE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module decode_pipe_stage #(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int REG_AW = 5,
   parameter int CTRL_W = 10
) (
   input  logic               CLK,
   input  logic               RST_N,
   decode_pipe_stage_if.slave bus
);

   typedef struct packed {
      logic [XLEN-1:0]   rd1;
      logic [XLEN-1:0]   rd2;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   imm;
      logic [XLEN-1:0]   pc4;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [REG_AW-1:0] rd;
      logic [CTRL_W-1:0] ctrl;
   } idex_t;

   logic [REG_AW-1:0] rs1_d;
   logic [REG_AW-1:0] rs2_d;
   logic [REG_AW-1:0] rd_d;
   logic              wr_en;
   logic [XLEN-1:0]   rf_q [NREG];
   logic [XLEN-1:0]   rf_d [NREG];
   logic [XLEN-1:0]   rd1_d;
   logic [XLEN-1:0]   rd2_d;
   idex_t             idex_p1_d;
   idex_t             idex_p1_q;
   logic              vld_p1_d;
   logic              vld_p1_q;
   logic              unused_instr;

   // ---- Decode (p0): field extraction and register file read ----
   assign rs1_d     = bus.InstrD[15 +: REG_AW];
   assign rs2_d     = bus.InstrD[20 +: REG_AW];
   assign rd_d      = bus.InstrD[7 +: REG_AW];
   assign bus.Rs1D  = rs1_d;
   assign bus.Rs2D  = rs2_d;
   // Opcode/funct bits are decoded upstream into CtrlD; only index fields are used here.
   assign unused_instr = ^bus.InstrD;

   assign wr_en = bus.RegWriteW && (bus.RdW != '0);

   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         rf_d[i] = rf_q[i];
      end
      if (wr_en) begin
         rf_d[bus.RdW] = bus.ResultW;
      end
      rf_d[0] = '0;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < NREG; i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREG; i++) begin
            rf_q[i] <= rf_d[i];
         end
      end
   end

   always_comb begin
      rd1_d = (rs1_d == '0) ? '0 : rf_q[rs1_d];
      rd2_d = (rs2_d == '0) ? '0 : rf_q[rs2_d];
`ifdef DECODE_PIPE_STAGE_BYPASS_EN
      if (wr_en && (bus.RdW == rs1_d)) begin
         rd1_d = bus.ResultW;
      end
      if (wr_en && (bus.RdW == rs2_d)) begin
         rd2_d = bus.ResultW;
      end
`endif
   end

   // ---- ID/EX boundary (p1): flush beats stall; a stall holds even stale operands ----
   always_comb begin
      idex_p1_d = idex_p1_q;
      vld_p1_d  = vld_p1_q;
      if (bus.FlushE) begin
         idex_p1_d = '0;
         vld_p1_d  = 1'b0;
      end else if (!bus.StallE) begin
         idex_p1_d.rd1  = rd1_d;
         idex_p1_d.rd2  = rd2_d;
         idex_p1_d.pc   = bus.PCD;
         idex_p1_d.imm  = bus.ImmExtD;
         idex_p1_d.pc4  = bus.PCPlus4D;
         idex_p1_d.rs1  = rs1_d;
         idex_p1_d.rs2  = rs2_d;
         idex_p1_d.rd   = rd_d;
         idex_p1_d.ctrl = bus.CtrlD;
         vld_p1_d       = bus.ValidD;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         idex_p1_q <= '0;
         vld_p1_q  <= 1'b0;
      end else begin
         idex_p1_q <= idex_p1_d;
         vld_p1_q  <= vld_p1_d;
      end
   end

   assign bus.RD1E     = idex_p1_q.rd1;
   assign bus.RD2E     = idex_p1_q.rd2;
   assign bus.PCE      = idex_p1_q.pc;
   assign bus.ImmExtE  = idex_p1_q.imm;
   assign bus.PCPlus4E = idex_p1_q.pc4;
   assign bus.Rs1E     = idex_p1_q.rs1;
   assign bus.Rs2E     = idex_p1_q.rs2;
   assign bus.RdE      = idex_p1_q.rd;
   assign bus.ControlE = idex_p1_q.ctrl;
   assign bus.ValidE   = vld_p1_q;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Self-checking bench for decode_pipe_stage: directed table, hand-written stall/flush/reset
// sequences and a randomized run against an array-based reference model.
module tb_decode_pipe_stage;
   localparam int XLEN   = 32;
   localparam int NREG   = 32;
   localparam int REG_AW = 5;
   localparam int CTRL_W = 10;
`ifdef DECODE_PIPE_STAGE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   always #5 CLK = ~CLK;

   decode_pipe_stage_if #(.XLEN(XLEN), .REG_AW(REG_AW), .CTRL_W(CTRL_W)) bus ();

   decode_pipe_stage #(.XLEN(XLEN), .NREG(NREG), .REG_AW(REG_AW), .CTRL_W(CTRL_W)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] rd1, rd2, pc, imm, pc4;
      logic [4:0]  rs1, rs2, rd;
      logic [9:0]  ctrl;
      logic        vld;
   } e_t;

   typedef struct {
      logic [31:0] instr, pc;
      logic [9:0]  ctrl;
      logic        valid, we;
      logic [4:0]  wrd;
      logic [31:0] result;
      logic [31:0] e_rd1, e_rd2;
      logic [4:0]  e_rd;
   } vec_t;

   int n_chk = 0;
   int n_fail = 0;
   logic [31:0] m_rf [32];
   e_t m_e;
   e_t ez;
   vec_t vt [6];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk_e(input string tag, input e_t exp);
      chk({tag, ".RD1E"}, bus.RD1E, exp.rd1);
      chk({tag, ".RD2E"}, bus.RD2E, exp.rd2);
      chk({tag, ".PCE"}, bus.PCE, exp.pc);
      chk({tag, ".ImmExtE"}, bus.ImmExtE, exp.imm);
      chk({tag, ".PCPlus4E"}, bus.PCPlus4E, exp.pc4);
      chk({tag, ".Rs1E"}, 32'(bus.Rs1E), 32'(exp.rs1));
      chk({tag, ".Rs2E"}, 32'(bus.Rs2E), 32'(exp.rs2));
      chk({tag, ".RdE"}, 32'(bus.RdE), 32'(exp.rd));
      chk({tag, ".ControlE"}, 32'(bus.ControlE), 32'(exp.ctrl));
      chk({tag, ".ValidE"}, 32'(bus.ValidE), 32'(exp.vld));
   endtask

   task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic [9:0] ctrl,
                        input logic valid, input logic stall, input logic flush,
                        input logic we, input logic [4:0] wrd, input logic [31:0] result);
      bus.InstrD    = instr;
      bus.PCD       = pc;
      bus.PCPlus4D  = pc + 32'd4;
      bus.ImmExtD   = {{20{instr[31]}}, instr[31:20]};
      bus.CtrlD     = ctrl;
      bus.ValidD    = valid;
      bus.StallE    = stall;
      bus.FlushE    = flush;
      bus.RegWriteW = we;
      bus.RdW       = wrd;
      bus.ResultW   = result;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
      m_e = ez;
   endtask

   // Architectural rules: read old contents (or forwarded result), update ID/EX, then commit write.
   task automatic model_tick();
      logic [4:0]  a, b;
      logic [31:0] r1, r2;
      a  = bus.InstrD[19:15];
      b  = bus.InstrD[24:20];
      r1 = m_rf[a];
      r2 = m_rf[b];
      if (BYP && bus.RegWriteW && bus.RdW != 5'd0) begin
         if (bus.RdW == a) r1 = bus.ResultW;
         if (bus.RdW == b) r2 = bus.ResultW;
      end
      if (bus.FlushE) begin
         m_e = ez;
      end else if (!bus.StallE) begin
         m_e.rd1  = r1;
         m_e.rd2  = r2;
         m_e.pc   = bus.PCD;
         m_e.imm  = bus.ImmExtD;
         m_e.pc4  = bus.PCPlus4D;
         m_e.rs1  = a;
         m_e.rs2  = b;
         m_e.rd   = bus.InstrD[11:7];
         m_e.ctrl = bus.CtrlD;
         m_e.vld  = bus.ValidD;
      end
      if (bus.RegWriteW && bus.RdW != 5'd0) m_rf[bus.RdW] = bus.ResultW;
   endtask

   task automatic tick();
      model_tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      e_t exp;
      ez = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 10'h0, 1'b0};
      vt[0] = '{32'h00000000, 32'h00, 10'h000, 1'b0, 1'b1, 5'd3, 32'hDEADBEEF,
                32'h0, 32'h0, 5'd0};
      vt[1] = '{32'h00318233, 32'h40, 10'h2A5, 1'b1, 1'b0, 5'd0, 32'h0,
                32'hDEADBEEF, 32'hDEADBEEF, 5'd4};
      vt[2] = '{32'h00000000, 32'h44, 10'h001, 1'b1, 1'b1, 5'd0, 32'hFFFFFFFF,
                32'h0, 32'h0, 5'd0};
      vt[3] = '{32'h00000033, 32'h48, 10'h002, 1'b1, 1'b0, 5'd0, 32'h0,
                32'h0, 32'h0, 5'd0};
      vt[4] = '{32'h003380B3, 32'h4C, 10'h004, 1'b1, 1'b1, 5'd7, 32'h55,
                (BYP ? 32'h55 : 32'h0), 32'hDEADBEEF, 5'd1};
      vt[5] = '{32'h00738133, 32'h50, 10'h008, 1'b1, 1'b0, 5'd0, 32'h0,
                32'h55, 32'h55, 5'd2};

      // Power-on reset with a write request pending.
      drive(32'h00318233, 32'h10, 10'h3FF, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'hCAFE);
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      chk_e("por", ez);
      drive(32'h0, 32'h0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      RST_N = 1'b1;

      // Directed table: pass-through, x0 discard, write/read collision.
      for (int i = 0; i < 6; i++) begin
         drive(vt[i].instr, vt[i].pc, vt[i].ctrl, vt[i].valid, 1'b0, 1'b0,
               vt[i].we, vt[i].wrd, vt[i].result);
         #1;
         chk($sformatf("vec%0d.Rs1D", i), 32'(bus.Rs1D), 32'(vt[i].instr[19:15]));
         chk($sformatf("vec%0d.Rs2D", i), 32'(bus.Rs2D), 32'(vt[i].instr[24:20]));
         tick();
         exp = '{vt[i].e_rd1, vt[i].e_rd2, vt[i].pc, {{20{vt[i].instr[31]}}, vt[i].instr[31:20]},
                 vt[i].pc + 32'd4, vt[i].instr[19:15], vt[i].instr[24:20], vt[i].e_rd,
                 vt[i].ctrl, vt[i].valid};
         chk_e($sformatf("vec%0d", i), exp);
      end

      // Stall for three cycles while the instruction and writeback data change.
      drive(32'h00318233, 32'h80, 10'h155, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      tick();
      chk("stall_pre.RD1E", bus.RD1E, 32'hDEADBEEF);
      for (int k = 0; k < 3; k++) begin
         drive(32'h00738133, 32'h100 + 32'(k * 4), 10'h3FF, 1'b0, 1'b1, 1'b0,
               1'b1, 5'd3, 32'h1000 + 32'(k));
         tick();
         chk($sformatf("stall%0d.RD1E", k), bus.RD1E, 32'hDEADBEEF);
         chk($sformatf("stall%0d.PCE", k), bus.PCE, 32'h80);
         chk($sformatf("stall%0d.ControlE", k), 32'(bus.ControlE), 32'h155);
         chk($sformatf("stall%0d.RdE", k), 32'(bus.RdE), 32'd4);
         chk($sformatf("stall%0d.ValidE", k), 32'(bus.ValidE), 32'd1);
      end
      drive(32'h00318233, 32'h90, 10'h0AA, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      tick();
      chk("unstall.RD1E", bus.RD1E, 32'h1002);
      chk("unstall.RD2E", bus.RD2E, 32'h1002);
      chk("unstall.PCE", bus.PCE, 32'h90);
      chk("unstall.ControlE", 32'(bus.ControlE), 32'h0AA);

      // Flush wins over stall.
      drive(32'h00318233, 32'hA0, 10'h3C3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
      tick();
      chk_e("flush_stall", ez);

      // Mid-run reset during a stall with a write pending.
      drive(32'h0, 32'hB0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234);
      tick();
      drive(32'h00528333, 32'hC0, 10'h111, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      tick();
      chk("pre_rst.RD1E", bus.RD1E, 32'h1234);
      drive(32'h00528333, 32'hC4, 10'h222, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 32'hABCD);
      #2;
      RST_N = 1'b0;
      #1;
      chk_e("async_rst", ez);
      model_reset();
      @(posedge CLK);
      #1;
      chk("in_rst.ValidE", 32'(bus.ValidE), 32'd0);
      RST_N = 1'b1;
      drive(32'h00528333, 32'hC8, 10'h333, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      tick();
      chk("post_rst.RD1E", bus.RD1E, 32'h0);
      chk("post_rst.RD2E", bus.RD2E, 32'h0);
      chk("post_rst.PCE", bus.PCE, 32'hC8);
      chk("post_rst.ValidE", 32'(bus.ValidE), 32'd1);

      // Randomized traffic against the reference model.
      for (int n = 0; n < 400; n++) begin
         drive($urandom, $urandom, 10'($urandom), 1'($urandom),
               ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
               1'($urandom), 5'($urandom_range(0, 7)), $urandom);
         tick();
         chk_e($sformatf("rnd%0d", n), m_e);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
